uart_tx_arbiter: RTL and testbench

- Schedules the shared UART transmit framer between two FWFT frame queues: the local request queue (WREQ/RREQ frames) and the APB response queue (RRES frames).
- Pops one frame at a time and presents its 56-bit payload plus CMD to the framer.
- Tracks framer busy until the frame completes.
- Enforces response priority with bounded starvation of requests, rejects illegal commands, and aborts on a framer timeout.

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Arbitrates the shared UART transmit framer between the request queue and the
// response queue. Responses have priority, and a burst limit keeps requests from starving.
module uart_tx_arbiter #(
    parameter int MAX_RES_BURST = 3,
    parameter int TIMEOUT       = 1023,
    parameter int TW            = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        tx_vld,
    input  logic [55:0] tx_data,
    input  logic [2:0]  tx_cmd,
    output logic        tx_ren,
    input  logic        res_vld,
    input  logic [55:0] res_data,
    input  logic [2:0]  res_cmd,
    output logic        res_ren,
    input  logic        frm_dbusy,
    output logic [55:0] frm_pdata,
    output logic [2:0]  frm_cmd,
    output logic        frm_vld,
    output logic        frm_sel,
    output logic        arb_busy,
    output logic        cmd_err,
    output logic        timeout_err
);

    localparam int SW = (MAX_RES_BURST < 1) ? 1 : $clog2(MAX_RES_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RES_BURST);
    localparam logic [TW-1:0] TMO        = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CHECK, PRESENT, ACTIVE} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [55:0]   pdata_nxt;
    logic [2:0]    cmd_nxt;
    logic          sel_nxt, vld_nxt, tx_ren_nxt, res_ren_nxt, cmd_err_nxt, tmo_nxt;
    logic          res_win;

    function automatic logic cmd_legal(input logic [2:0] c);
        return (c == 3'd2) || (c == 3'd3) || (c == 3'd4);
    endfunction

    function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
        return (s == STREAK_MAX) ? s : s + 1'b1;
    endfunction

    always_comb begin
        state_nxt   = state;
        streak_nxt  = streak;
        timer_nxt   = timer;
        pdata_nxt   = frm_pdata;
        cmd_nxt     = frm_cmd;
        sel_nxt     = frm_sel;
        vld_nxt     = frm_vld;
        tx_ren_nxt  = 1'b0;
        res_ren_nxt = 1'b0;
        cmd_err_nxt = 1'b0;
        tmo_nxt     = 1'b0;
        res_win     = res_vld && !(tx_vld && (streak == STREAK_MAX));

        case (state)
            IDLE: begin
                if ((tx_vld || res_vld) && !frm_dbusy) begin
                    timer_nxt = '0;
                    state_nxt = CHECK;
                    if (res_win) begin
                        pdata_nxt   = res_data;
                        cmd_nxt     = res_cmd;
                        sel_nxt     = 1'b1;
                        res_ren_nxt = 1'b1;
                        streak_nxt  = tx_vld ? streak_inc(streak) : '0;
                    end else begin
                        pdata_nxt  = tx_data;
                        cmd_nxt    = tx_cmd;
                        sel_nxt    = 1'b0;
                        tx_ren_nxt = 1'b1;
                        streak_nxt = '0;
                    end
                end
            end
            CHECK: begin
                if (!cmd_legal(frm_cmd)) begin
                    cmd_err_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    vld_nxt   = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT, ACTIVE: begin
                timer_nxt = timer + 1'b1;
                // A timeout wins even if the framer changes busy on the same edge
                if (timer_nxt == TMO) begin
                    tmo_nxt   = 1'b1;
                    vld_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else if ((state == PRESENT) && frm_dbusy) begin
                    vld_nxt   = 1'b0;
                    state_nxt = ACTIVE;
                end else if ((state == ACTIVE) && !frm_dbusy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            streak      <= '0;
            timer       <= '0;
            frm_pdata   <= '0;
            frm_cmd     <= '0;
            frm_sel     <= 1'b0;
            frm_vld     <= 1'b0;
            tx_ren      <= 1'b0;
            res_ren     <= 1'b0;
            cmd_err     <= 1'b0;
            timeout_err <= 1'b0;
            arb_busy    <= 1'b0;
        end else begin
            state       <= state_nxt;
            streak      <= streak_nxt;
            timer       <= timer_nxt;
            frm_pdata   <= pdata_nxt;
            frm_cmd     <= cmd_nxt;
            frm_sel     <= sel_nxt;
            frm_vld     <= vld_nxt;
            tx_ren      <= tx_ren_nxt;
            res_ren     <= res_ren_nxt;
            cmd_err     <= cmd_err_nxt;
            timeout_err <= tmo_nxt;
            arb_busy    <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a default-timeout instance for normal traffic
// and a TIMEOUT=15 instance with its own queue/framer inputs for the timeout case.
module tb_uart_tx_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        tx_vld = 1'b0, res_vld = 1'b0, frm_dbusy = 1'b0;
    logic [55:0] tx_data = '0, res_data = '0;
    logic [2:0]  tx_cmd = '0, res_cmd = '0;
    logic        tx_ren, res_ren, frm_vld, frm_sel, arb_busy, cmd_err, timeout_err;
    logic [55:0] frm_pdata;
    logic [2:0]  frm_cmd;

    logic        t_tx_vld = 1'b0, t_res_vld = 1'b0, t_dbusy = 1'b0;
    logic        t_tx_ren, t_res_ren, t_frm_vld, t_frm_sel, t_arb_busy, t_cmd_err, t_timeout_err;
    logic [55:0] t_frm_pdata;
    logic [2:0]  t_frm_cmd;

    int errors = 0;
    int checks = 0;

    localparam logic [55:0] P1 = 56'h02_1234_5678_9ABC;
    localparam logic [55:0] PA = 56'h03_AAAA_0000_1111;
    localparam logic [55:0] PB = 56'h04_BBBB_2222_3333;
    localparam logic [55:0] PC = 56'h03_CCCC_4444_5555;

    always #5 CLK = ~CLK;

    uart_tx_arbiter dut (
        .CLK(CLK), .RST(RST),
        .tx_vld(tx_vld), .tx_data(tx_data), .tx_cmd(tx_cmd), .tx_ren(tx_ren),
        .res_vld(res_vld), .res_data(res_data), .res_cmd(res_cmd), .res_ren(res_ren),
        .frm_dbusy(frm_dbusy), .frm_pdata(frm_pdata), .frm_cmd(frm_cmd),
        .frm_vld(frm_vld), .frm_sel(frm_sel), .arb_busy(arb_busy),
        .cmd_err(cmd_err), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.MAX_RES_BURST(3), .TIMEOUT(15), .TW(4)) dut_t (
        .CLK(CLK), .RST(RST),
        .tx_vld(t_tx_vld), .tx_data(tx_data), .tx_cmd(tx_cmd), .tx_ren(t_tx_ren),
        .res_vld(t_res_vld), .res_data(res_data), .res_cmd(res_cmd), .res_ren(t_res_ren),
        .frm_dbusy(t_dbusy), .frm_pdata(t_frm_pdata), .frm_cmd(t_frm_cmd),
        .frm_vld(t_frm_vld), .frm_sel(t_frm_sel), .arb_busy(t_arb_busy),
        .cmd_err(t_cmd_err), .timeout_err(t_timeout_err)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Framer handshake for the main instance, starting right after a grant edge
    task automatic serve(input string tag);
        step();
        chk({tag, "_vld"}, frm_vld, 1'b1);
        frm_dbusy = 1'b1;
        step();
        frm_dbusy = 1'b0;
        step();
        chk({tag, "_idle"}, arb_busy, 1'b0);
    endtask

    initial begin
        int exp_sel[8];
        logic bad;
        exp_sel = '{1, 1, 1, 0, 1, 1, 1, 0};

        // Reset state
        step(); step();
        chk("rst_vld", frm_vld, 1'b0);
        chk("rst_busy", arb_busy, 1'b0);
        chk("rst_ren", {tx_ren, res_ren}, 2'b00);
        chk("rst_err", {cmd_err, timeout_err}, 2'b00);
        chk("rst_pdata", frm_pdata, 56'h0);
        chk("rst_cmd_sel", {frm_cmd, frm_sel}, 4'h0);
        chk("rst_t_busy", t_arb_busy, 1'b0);

        // Single request
        RST = 1'b1; tx_vld = 1'b1; tx_cmd = 3'd2; tx_data = P1;
        step();
        chk("s1_tx_ren", {tx_ren, res_ren}, 2'b10);
        chk("s1_pdata", frm_pdata, P1);
        chk("s1_sel_cmd", {frm_sel, frm_cmd}, {1'b0, 3'd2});
        chk("s1_busy", arb_busy, 1'b1);
        chk("s1_vld0", frm_vld, 1'b0);
        tx_vld = 1'b0;
        step();
        chk("s1_vld1", frm_vld, 1'b1);
        chk("s1_ren_off", tx_ren, 1'b0);
        step(); step();
        chk("s1_vld_hold", frm_vld, 1'b1);
        frm_dbusy = 1'b1;
        step();
        chk("s1_vld_clr", frm_vld, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 19; i++) begin
            step();
            if (arb_busy !== 1'b1 || frm_vld !== 1'b0 || tx_ren !== 1'b0) bad = 1'b1;
        end
        chk("s1_active_hold", bad, 1'b0);
        frm_dbusy = 1'b0;
        step();
        chk("s1_busy_fall", arb_busy, 1'b0);
        chk("s1_no_err", {cmd_err, timeout_err}, 2'b00);
        chk("s1_pdata_kept", frm_pdata, P1);

        // Simultaneous requests: response goes first
        tx_vld = 1'b1; tx_cmd = 3'd3; tx_data = PA;
        res_vld = 1'b1; res_cmd = 3'd4; res_data = PB;
        step();
        chk("sim_res_ren", {tx_ren, res_ren}, 2'b01);
        chk("sim_res_sel", frm_sel, 1'b1);
        chk("sim_res_pdata", frm_pdata, PB);
        res_vld = 1'b0;
        serve("sim_res");
        step();
        chk("sim_tx_ren", {tx_ren, res_ren}, 2'b10);
        chk("sim_tx_sel", frm_sel, 1'b0);
        chk("sim_tx_pdata", frm_pdata, PA);
        chk("sim_tx_cmd", frm_cmd, 3'd3);
        tx_vld = 1'b0;
        serve("sim_tx");

        // Starvation bound with both queues always full
        tx_vld = 1'b1; res_vld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("starve_g%0d", i), {tx_ren, res_ren},
                (exp_sel[i] == 1) ? 2'b01 : 2'b10);
            serve($sformatf("starve_s%0d", i));
        end
        tx_vld = 1'b0; res_vld = 1'b0;

        // Illegal command
        tx_vld = 1'b1; tx_cmd = 3'd7; tx_data = PA;
        step();
        chk("ill_ren", tx_ren, 1'b1);
        tx_vld = 1'b0;
        step();
        chk("ill_err", cmd_err, 1'b1);
        chk("ill_vld", frm_vld, 1'b0);
        chk("ill_idle", arb_busy, 1'b0);
        step();
        chk("ill_err_once", cmd_err, 1'b0);
        chk("ill_vld_after", frm_vld, 1'b0);

        // Timeout on the short-timeout instance; a second frame stays queued
        tx_cmd = 3'd2; tx_data = P1; t_tx_vld = 1'b1;
        step();
        chk("tmo_ren", t_tx_ren, 1'b1);
        step();
        chk("tmo_present", t_frm_vld, 1'b1);
        bad = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (t_timeout_err !== 1'b0 || t_frm_vld !== 1'b1) bad = 1'b1;
        end
        chk("tmo_early", bad, 1'b0);
        step();
        chk("tmo_err", t_timeout_err, 1'b1);
        chk("tmo_vld", t_frm_vld, 1'b0);
        chk("tmo_idle", t_arb_busy, 1'b0);
        step();
        chk("tmo_err_once", t_timeout_err, 1'b0);
        chk("tmo_next_grant", t_tx_ren, 1'b1);
        t_tx_vld = 1'b0;

        // Reset during ACTIVE
        tx_vld = 1'b1; tx_cmd = 3'd2; tx_data = P1;
        step();
        tx_vld = 1'b0;
        step();
        frm_dbusy = 1'b1;
        step(); step();
        chk("rm_active", {arb_busy, frm_vld}, 2'b10);
        RST = 1'b0;
        step();
        chk("rm_busy", arb_busy, 1'b0);
        chk("rm_outs", {frm_vld, frm_sel, tx_ren, res_ren, cmd_err, timeout_err}, 6'b0);
        chk("rm_pdata", frm_pdata, 56'h0);
        chk("rm_cmd", frm_cmd, 3'd0);
        RST = 1'b1; frm_dbusy = 1'b0;
        step();
        chk("rm_no_err", {cmd_err, timeout_err, arb_busy}, 3'b000);
        tx_vld = 1'b1; tx_cmd = 3'd3; tx_data = PC;
        step();
        chk("rm_resume_ren", tx_ren, 1'b1);
        chk("rm_resume_pdata", frm_pdata, PC);
        tx_vld = 1'b0;
        serve("rm_resume");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
